cam_hit_stats: RTL

Downstream statistics collector for the CAM lookup stage. Each cycle it samples the CAM's lookup result (`addr`, `valid`, `num_match`) and keeps per-entry hit counters, plus totals for lookups, misses and multi-matches. On request it streams all counters out over a valid/ready handshake, so a test harness or debug port can read profiling data without stopping lookups.

---
 rtl/cam_hit_stats.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cam_hit_stats.sv
// CAM lookup statistics: per-entry hit counters plus lookup/miss/multi totals, dumped over valid/ready.
// Define CAM_STATS_MULTI_EN to build the multi-match counter; otherwise its dump beat reads as zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | sampling only, no dump in progress
// DUMP  | presenting beats 0..ENTRIES+2 on out_valid/out_ready
// DONE  | one-cycle done pulse after the last beat, then back to IDLE
module cam_hit_stats #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 3,
    parameter int MATCH_W = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_en,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               valid,
    input  logic [MATCH_W-1:0] num_match,
    input  logic               clear,
    input  logic               dump_start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_idx,
    output logic [CNT_W-1:0]   out_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DUMP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]   ENTRIES_W = (ADDR_W+1)'(ENTRIES);
    localparam logic [3:0]        LOOKUP_IDX = 4'(ENTRIES);
    localparam logic [3:0]        MISS_IDX   = 4'(ENTRIES + 1);
    localparam logic [3:0]        LAST_IDX   = 4'(ENTRIES + 2);

    logic [1:0]       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] hit_cnt_q [ENTRIES];
    logic [CNT_W-1:0] hit_cnt_d [ENTRIES];
    logic [CNT_W-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             err_q, err_d;
    logic             addr_oor;
    logic             bad_result;

    assign addr_oor   = valid && ({1'b0, addr} >= ENTRIES_W);
    assign bad_result = (valid && (num_match == '0)) || (!valid && (num_match != '0));

    // clear has priority over a same-cycle sample, which is then dropped
    always_comb begin
        hit_cnt_d    = hit_cnt_q;
        lookup_cnt_d = lookup_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        err_d        = err_q;
        if (clear) begin
            hit_cnt_d    = '{default: '0};
            lookup_cnt_d = '0;
            miss_cnt_d   = '0;
            err_d        = 1'b0;
        end else if (in_en) begin
            if (lookup_cnt_q != CNT_MAX) lookup_cnt_d = lookup_cnt_q + CNT_ONE;
            if (!valid && (miss_cnt_q != CNT_MAX)) miss_cnt_d = miss_cnt_q + CNT_ONE;
            for (int i = 0; i < ENTRIES; i++) begin
                if (valid && (addr == ADDR_W'(i)) && (hit_cnt_q[i] != CNT_MAX))
                    hit_cnt_d[i] = hit_cnt_q[i] + CNT_ONE;
            end
            if (addr_oor || bad_result) err_d = 1'b1;
        end
    end

`ifdef CAM_STATS_MULTI_EN
    logic [CNT_W-1:0] multi_cnt_q, multi_cnt_d;

    always_comb begin
        multi_cnt_d = multi_cnt_q;
        if (clear) begin
            multi_cnt_d = '0;
        end else if (in_en && valid && (num_match > MATCH_W'(1)) && (multi_cnt_q != CNT_MAX)) begin
            multi_cnt_d = multi_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) multi_cnt_q <= '0;
        else       multi_cnt_q <= multi_cnt_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    state_d = S_DUMP;
                    idx_d   = '0;
                end
            end
            S_DUMP: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            hit_cnt_q    <= '{default: '0};
            lookup_cnt_q <= '0;
            miss_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hit_cnt_q    <= hit_cnt_d;
            lookup_cnt_q <= lookup_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            err_q        <= err_d;
        end
    end

    // live counters muxed by the registered beat index
    always_comb begin
        out_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (idx_q == 4'(i)) out_data = hit_cnt_q[i];
        end
        if (idx_q == LOOKUP_IDX) out_data = lookup_cnt_q;
        if (idx_q == MISS_IDX)   out_data = miss_cnt_q;
`ifdef CAM_STATS_MULTI_EN
        if (idx_q == LAST_IDX)   out_data = multi_cnt_q;
`endif
    end

    assign out_valid = (state_q == S_DUMP);
    assign busy      = (state_q == S_DUMP);
    assign done      = (state_q == S_DONE);
    assign out_idx   = idx_q;
    assign err       = err_q;

endmodule
